// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage; owns PC, fetches over req/ack, decodes fields for ctrl
//   clk, rst                     : clock, async active-high reset
//   imem_req/addr/ack/rdata      : instruction memory handshake
//   instr_ready, PCSrc, ImmExt   : consume strobe and next-PC select from ctrl
//   instr_valid, Instr, PC       : current fetched instruction and its address
//   PCPlus4, op, funct3, funct7  : combinational helpers for ctrl
//   pc_misaligned                : sticky, a computed target had low bits set
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        instr_ready,
  input  logic        PCSrc,
  input  logic [31:0] ImmExt,
  output logic        instr_valid,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7,
  output logic        pc_misaligned
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  state_t r_state, w_next;
  logic [31:0] r_fetch_pc, r_pc, r_instr, w_target;
  logic        r_valid, r_mis;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? REQ :
             r_state == REQ  ? (imem_ack ? HOLD : REQ) :
                               (instr_ready ? REQ : HOLD);
  end
  assign w_target = PCSrc ? r_pc + ImmExt : r_pc + 32'd4;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_pc       <= RESET_PC;
      r_instr    <= NOP_INSTR;
      r_valid    <= 1'b0;
      r_mis      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == REQ && imem_ack) begin
        r_instr <= imem_rdata;
        r_pc    <= r_fetch_pc;
        r_valid <= 1'b1;
      end
      if (r_state == HOLD && instr_ready) begin
        r_fetch_pc <= {w_target[31:2], 2'b00};
        r_mis      <= r_mis | (|w_target[1:0]);
        r_valid    <= 1'b0;
        r_instr    <= NOP_INSTR;
      end
    end
  assign imem_req      = r_state == REQ;
  assign imem_addr     = r_fetch_pc;
  assign instr_valid   = r_valid;
  assign Instr         = r_instr;
  assign PC            = r_pc;
  assign PCPlus4       = r_pc + 32'd4;
  assign op            = r_instr[6:0];
  assign funct3        = r_instr[14:12];
  assign funct7        = r_instr[30];
  assign pc_misaligned = r_mis;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0, rst = 0;
  logic imem_req, imem_ack = 0, instr_ready = 0, PCSrc = 0, instr_valid, funct7, pc_misaligned;
  logic [31:0] imem_addr, imem_rdata = 0, ImmExt = 0, Instr, PC, PCPlus4;
  logic [6:0] op;
  logic [2:0] funct3;
  logic req_w, ack_w = 0, ready_w = 0, valid_w, f7_w, mis_w;
  logic [31:0] addr_w, instr_w, pc_w, pc4_w;
  logic [6:0] op_w;
  logic [2:0] f3_w;
  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_fetch = 0, cur_pc = 0;
  logic exp_mis = 0, prev_valid = 0;
  logic [63:0] sb[$];
  always #5 clk = ~clk;
  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_ready(instr_ready), .PCSrc(PCSrc), .ImmExt(ImmExt),
    .instr_valid(instr_valid), .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4), .op(op),
    .funct3(funct3), .funct7(funct7), .pc_misaligned(pc_misaligned)
  );
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .imem_req(req_w), .imem_addr(addr_w), .imem_ack(ack_w),
    .imem_rdata(32'h0000_0033), .instr_ready(ready_w), .PCSrc(1'b0), .ImmExt(32'd0),
    .instr_valid(valid_w), .Instr(instr_w), .PC(pc_w), .PCPlus4(pc4_w), .op(op_w),
    .funct3(f3_w), .funct7(f7_w), .pc_misaligned(mis_w)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #2;
    if (instr_valid && !prev_valid) begin
      if (sb.size() == 0) check("sb_empty", instr_valid, 0);
      else begin
        logic [63:0] e;
        e = sb.pop_front();
        check("sb_pc", PC, e[63:32]);
        check("sb_instr", Instr, e[31:0]);
        check("sb_op", {25'd0, op}, {25'd0, e[6:0]});
        check("sb_funct3", {29'd0, funct3}, {29'd0, e[14:12]});
        check("sb_funct7", {31'd0, funct7}, {31'd0, e[30]});
        check("sb_pc4", PCPlus4, e[63:32] + 32'd4);
      end
    end
    prev_valid = instr_valid;
  end
  task automatic fetch(input int lat, input logic [31:0] data);
    int k = 0;
    while (!imem_req && k < 20) begin @(negedge clk); k++; end
    if (!imem_req) begin check("req_timeout", imem_req, 1); return; end
    check("addr", imem_addr, exp_fetch);
    repeat (lat) begin
      @(posedge clk); @(negedge clk);
      check("req_hold", imem_req, 1);
      check("addr_hold", imem_addr, exp_fetch);
      check("valid_early", instr_valid, 0);
    end
    imem_rdata = data; imem_ack = 1;
    sb.push_back({exp_fetch, data});
    cur_pc = exp_fetch;
    @(posedge clk); @(negedge clk);
    imem_ack = 0;
    check("valid", instr_valid, 1);
    check("req_off", imem_req, 0);
  endtask
  task automatic consume(input logic s, input logic [31:0] imm);
    logic [31:0] t;
    t = s ? cur_pc + imm : cur_pc + 32'd4;
    PCSrc = s; ImmExt = imm; instr_ready = 1;
    @(posedge clk); @(negedge clk);
    instr_ready = 0; PCSrc = 0; ImmExt = 0;
    exp_fetch = {t[31:2], 2'b00};
    if (t[1:0] != 2'b00) exp_mis = 1;
    check("valid_drop", instr_valid, 0);
    check("nop", Instr, NOP);
    check("nop_op", {25'd0, op}, 32'h13);
    check("mis", pc_misaligned, exp_mis);
    check("req_on", imem_req, 1);
    check("addr_next", imem_addr, exp_fetch);
  endtask
  initial begin
    #2 rst = 1;
    #1;
    check("rst_req", imem_req, 0);
    check("rst_pc", PC, 0);
    check("rst_instr", Instr, NOP);
    check("rst_valid", instr_valid, 0);
    check("rst_mis", pc_misaligned, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    fetch(0, 32'h0000_0083);
    check("lw_op", {25'd0, op}, 32'h03);
    check("lw_pc4", PCPlus4, 4);
    consume(0, 0);
    fetch(1, 32'h4000_5033);
    for (int i = 0; i < 5; i++) begin
      imem_ack = i[0]; PCSrc = 1; ImmExt = $urandom;
      @(posedge clk); @(negedge clk);
      check("stall_instr", Instr, 32'h4000_5033);
      check("stall_pc", PC, 4);
      check("stall_req", imem_req, 0);
      check("stall_valid", instr_valid, 1);
    end
    imem_ack = 0; PCSrc = 0;
    consume(0, 0);
    fetch(0, 32'h0010_0093); consume(0, 0);
    fetch(2, 32'h0020_0113); consume(0, 0);
    fetch(0, 32'hFE00_0EE3); consume(1, 32'hFFFF_FFF8);
    check("br_back", imem_addr, 32'h08);
    fetch(0, 32'h0000_0463); consume(1, 32'h8);
    fetch(0, 32'h0000_0363); consume(1, 32'h6);
    check("br_mis_addr", imem_addr, 32'h14);
    check("br_mis_flag", pc_misaligned, 1);
    fetch(4, 32'h0041_8193); consume(0, 0);
    check("mis_sticky", pc_misaligned, 1);
    fetch(0, 32'h0000_0013); consume(0, 0);
    check("wrap_req", req_w, 1);
    check("wrap_addr", addr_w, 32'hFFFF_FFFC);
    ack_w = 1;
    @(posedge clk); @(negedge clk);
    ack_w = 0;
    check("wrap_valid", valid_w, 1);
    check("wrap_pc", pc_w, 32'hFFFF_FFFC);
    check("wrap_pc4", pc4_w, 0);
    ready_w = 1;
    @(posedge clk); @(negedge clk);
    ready_w = 0;
    check("wrap_next", addr_w, 0);
    check("wrap_mis", mis_w, 0);
    check("mid_req", imem_req, 1);
    #2 rst = 1;
    #1;
    check("mid_req_drop", imem_req, 0);
    check("mid_pc", PC, 0);
    check("mid_mis", pc_misaligned, 0);
    @(negedge clk);
    rst = 0; imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); @(negedge clk);
    imem_ack = 0;
    check("stale_valid", instr_valid, 0);
    check("stale_instr", Instr, NOP);
    exp_fetch = 0; exp_mis = 0;
    fetch(1, 32'h0000_0513);
    consume(0, 0);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
